// File: rtl/umips_muldiv_ctrl.sv
// umips_muldiv_ctrl: iterative multiply/divide sequencer that owns HI/LO.
// Handles MULT/MULTU (shift-add) and DIV/DIVU (restoring). Each operation takes
// one bit per cycle, and HI/LO are written only on completion. It also handles
// MTHI/MTLO in IDLE, and raises a stall toward the hazard unit while busy.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        launch op on op/a/b (sampled only in IDLE)
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b         rs / rt operands
//   mthi, mtlo   write wdata to HI / LO (honoured only in IDLE, start wins)
//   wdata        data for mthi/mtlo
//   hilo_use_d   decode-stage instruction touches HI/LO
//   hi, lo       HI / LO registers
//   busy         state is not IDLE
//   done         one-cycle pulse after HI/LO update
//   stall        busy & hilo_use_d (combinational)
module umips_muldiv_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             hilo_use_d,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             div_q, div_d;      // operation is a divide
  logic             neg_q, neg_d;      // negate product / quotient
  logic             rneg_q, rneg_d;    // negate remainder (dividend sign)
  logic [WIDTH-1:0] opnd_q, opnd_d;    // multiplicand or divisor magnitude
  logic [W2-1:0]    work_q, work_d;    // product, or {remainder, quotient}
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             signed_op;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [W2-1:0]    step_mul, step_div;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic             div_by_zero;

  // Operand magnitudes for the signed ops (MULT/DIV have op[0]=0)
  assign signed_op = ~op[0];
  assign mag_a     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign mag_b     = (signed_op && b[WIDTH-1]) ? -b : b;

  // Shift-add step: add multiplicand on LSB of multiplier, shift right
  assign mul_sum  = {1'b0, work_q[W2-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign step_mul = {mul_sum, work_q[WIDTH-1:1]};

  // Restoring step: shift next dividend bit into remainder, subtract if it fits
  assign div_shift = {work_q[W2-1:WIDTH], work_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_rem   = WIDTH'(div_shift - {1'b0, opnd_q});
  assign step_div  = {(div_ge ? div_rem : div_shift[WIDTH-1:0]), work_q[WIDTH-2:0], div_ge};

  // Sign fix-up; a zero divisor leaves the remainder equal to |a|, so the
  // dividend-sign fix-up restores the original a, and the quotient is forced.
  assign div_by_zero = (opnd_q == '0);
  assign prod_fix    = neg_q ? -work_q : work_q;
  assign quo_fix     = div_by_zero ? {WIDTH{1'b1}} :
                       (neg_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0]);
  assign rem_fix     = rneg_q ? -work_q[W2-1:WIDTH] : work_q[W2-1:WIDTH];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (count_q == CW'(WIDTH - 1)) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy  = (state_q != S_IDLE);
    stall = busy & hilo_use_d;
  end

  // Datapath next-state
  always_comb begin
    count_d = count_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    opnd_d  = opnd_q;
    work_d  = work_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d = '0;
          div_d   = op[1];
          neg_d   = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d  = signed_op & a[WIDTH-1];
          if (op[1]) begin
            opnd_d = mag_b;
            work_d = {{WIDTH{1'b0}}, mag_a};
          end else begin
            opnd_d = mag_a;
            work_d = {{WIDTH{1'b0}}, mag_b};
          end
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      S_RUN: begin
        work_d  = div_q ? step_div : step_mul;
        count_d = count_q + CW'(1);
      end
      S_FIN: begin
        done_d = 1'b1;
        if (div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[W2-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      opnd_q  <= '0;
      work_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      opnd_q  <= opnd_d;
      work_q  <= work_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = done_q;

endmodule

// File: tb/tb_umips_muldiv_ctrl.sv
// Self-checking bench for umips_muldiv_ctrl: directed and random operations
// compared against a plain-arithmetic HI/LO reference model.
module tb_umips_muldiv_ctrl;

  localparam int unsigned WIDTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        mthi, mtlo, hilo_use_d;
  logic [31:0] hi, lo;
  logic        busy, done, stall;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] hi_m = 32'h0;
  logic [31:0] lo_m = 32'h0;

  always #5 clk = ~clk;

  umips_muldiv_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .mthi       (mthi),
    .mtlo       (mtlo),
    .wdata      (wdata),
    .hilo_use_d (hilo_use_d),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .stall      (stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result {hi, lo} from the architectural definition
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] xa,
                                            input logic [31:0] xb);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(xa));
    sb = longint'($signed(xb));
    p  = 64'h0;
    case (o)
      2'b00: p = 64'(sa * sb);
      2'b01: p = {32'h0, xa} * {32'h0, xb};
      2'b10: begin
        if (xb == 32'h0) p = {xa, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (xb == 32'h0) p = {xa, 32'hFFFF_FFFF};
        else p = {xa % xb, xa / xb};
      end
    endcase
    return p;
  endfunction

  // One mul/div: fixed latency, HI/LO held during RUN, optional interference
  task automatic do_op(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                       input bit disturb, input bit launch_wr);
    logic [63:0] r;
    r = ref_model(o, xa, xb);
    @(negedge clk);
    start = 1'b1; op = o; a = xa; b = xb;
    if (launch_wr) begin
      mthi = 1'b1; mtlo = 1'b1; wdata = $urandom;
    end
    if (disturb) hilo_use_d = 1'b1;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    for (int c = 1; c <= int'(WIDTH) + 1; c++) begin
      chk("busy_run", 64'({busy, done}), 64'(2'b10));
      chk("hilo_hold", {hi, lo}, {hi_m, lo_m});
      if (disturb) begin
        chk("stall_busy", 64'(stall), 64'(1'b1));
        start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
        mthi = 1'b1; wdata = 32'h55;
      end
      @(negedge clk);
    end
    start = 1'b0; mthi = 1'b0;
    {hi_m, lo_m} = r;
    chk("done_pulse", 64'({busy, done}), 64'(2'b01));
    chk("result", {hi, lo}, r);
    if (disturb) chk("stall_idle", 64'(stall), 64'(1'b0));
    hilo_use_d = 1'b0;
    @(negedge clk);
    chk("done_clear", 64'({busy, done}), 64'(2'b00));
  endtask

  task automatic do_mt(input bit wh, input bit wl, input logic [31:0] d);
    @(negedge clk);
    mthi = wh; mtlo = wl; wdata = d;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    if (wh) hi_m = d;
    if (wl) lo_m = d;
    chk("mt_hilo", {hi, lo}, {hi_m, lo_m});
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0;
    mthi = 1'b0; mtlo = 1'b0; wdata = 32'h0; hilo_use_d = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_hilo", {hi, lo}, 64'h0);
    chk("rst_ctrl", 64'({busy, done, stall}), 64'(3'b000));
    rst = 1'b0; hilo_use_d = 1'b0;

    do_mt(1'b1, 1'b1, 32'h1234);

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 1'b0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
    do_op(2'b11, 32'd100,       32'd7,         1'b0, 1'b0);
    do_op(2'b11, 32'h0000_0064, 32'h0,         1'b0, 1'b0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(2'b10, 32'h8000_0000, 32'h0,         1'b0, 1'b0);
    do_op(2'b10, 32'hFFFF_FF00, 32'h0,         1'b0, 1'b0);
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    do_op(2'b01, 32'd6,         32'd7,         1'b1, 1'b0);

    do_mt(1'b1, 1'b0, $urandom);
    do_mt(1'b0, 1'b1, $urandom);
    do_op(2'b01, 32'd5, 32'd5, 1'b0, 1'b1);

    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = ($urandom_range(3) == 0) ? 32'h0 :
           (($urandom_range(1) == 0) ? 32'($urandom_range(255)) : 32'($urandom));
      do_op(ro, ra, rb, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    // Asynchronous reset in the middle of a DIV
    do_mt(1'b1, 1'b1, 32'hA5A5_A5A5);
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'hFFFF_0000; b = 32'h0000_0013;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("busy_pre_rst", 64'(busy), 64'(1'b1));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_hilo", {hi, lo}, 64'h0);
    chk("async_rst_ctrl", 64'({busy, done}), 64'(2'b00));
    @(negedge clk);
    rst = 1'b0; hi_m = 32'h0; lo_m = 32'h0;
    for (int c = 0; c < 40; c++) begin
      chk("no_done_after_rst", 64'({busy, done}), 64'(2'b00));
      @(negedge clk);
    end
    do_op(2'b01, 32'd3, 32'd4, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
